// File: rtl/tdm_scan_ctrl_if.sv
// Lane-scan stream bundle: frame request, lane inputs, mux select and the output beat stream.
// Handshake: a beat transfers on a rising clk edge where out_valid && out_ready; while
// out_valid is high and out_ready low, select/out_data/frame_start are held unchanged.
interface tdm_scan_if #(
   parameter int WIDTH = 1
);
   logic                 start;
   logic [3:0]           lane_mask;
   logic [4*WIDTH-1:0]   in_data;
   logic [1:0]           select;
   logic [WIDTH-1:0]     out_data;
   logic                 out_valid;
   logic                 out_ready;
   logic                 frame_start;
   logic                 busy;
   logic                 done;

   modport master (
      output start, lane_mask, in_data, out_ready,
      input  select, out_data, out_valid, frame_start, busy, done
   );

   modport slave (
      input  start, lane_mask, in_data, out_ready,
      output select, out_data, out_valid, frame_start, busy, done
   );
endinterface

// File: rtl/tdm_scan_ctrl.sv
// Upstream sequencer for a 4:1 lane mux: snapshots four lanes on start and streams the
// enabled lanes in ascending order as valid/ready beats, with optional idle gaps.
module tdm_scan_ctrl #(
   parameter int WIDTH      = 1,
   parameter int GAP        = 0,
   parameter int CONTINUOUS = 0
) (
   input  logic       clk,
   input  logic       rst,
   tdm_scan_if.slave  bus,
   output logic [2:0] dbg_state
);
   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] CAPTURE = 3'd1;
   localparam logic [2:0] SCAN    = 3'd2;
   localparam logic [2:0] GAPW    = 3'd3;
   localparam logic [2:0] DONE    = 3'd4;
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

   logic [2:0]         state;
   logic [GW-1:0]      gap_cnt;
   logic [4*WIDTH-1:0] snap_data;
   logic [3:0]         snap_mask;
   logic               has_next;
   logic [1:0]         next_lane;
   logic [1:0]         first_lane;

   assign dbg_state = state;

   // Descending loops leave the lowest qualifying lane as the winner.
   always_comb begin
      has_next   = 1'b0;
      next_lane  = bus.select;
      first_lane = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (snap_mask[i] && (i > int'(bus.select))) begin
            has_next  = 1'b1;
            next_lane = 2'(i);
         end
         if (bus.lane_mask[i]) begin
            first_lane = 2'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         gap_cnt         <= '0;
         snap_data       <= '0;
         snap_mask       <= '0;
         bus.select      <= '0;
         bus.out_data    <= '0;
         bus.out_valid   <= 1'b0;
         bus.frame_start <= 1'b0;
         bus.busy        <= 1'b0;
         bus.done        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start && (bus.lane_mask != 4'd0)) begin
                  state    <= CAPTURE;
                  bus.busy <= 1'b1;
               end
            end
            CAPTURE: begin
               snap_data <= bus.in_data;
               snap_mask <= bus.lane_mask;
               // A continuous rescan can land here with an empty mask; nothing to emit then.
               if (bus.lane_mask == 4'd0) begin
                  state    <= IDLE;
                  bus.busy <= 1'b0;
               end else begin
                  bus.select      <= first_lane;
                  bus.out_data    <= bus.in_data[first_lane*WIDTH +: WIDTH];
                  bus.out_valid   <= 1'b1;
                  bus.frame_start <= 1'b1;
                  state           <= SCAN;
               end
            end
            SCAN: begin
               if (bus.out_ready) begin
                  bus.frame_start <= 1'b0;
                  if (!has_next) begin
                     bus.out_valid <= 1'b0;
                     bus.done      <= 1'b1;
                     state         <= DONE;
                  end else if (GAP == 0) begin
                     bus.select   <= next_lane;
                     bus.out_data <= snap_data[next_lane*WIDTH +: WIDTH];
                  end else begin
                     bus.out_valid <= 1'b0;
                     gap_cnt       <= '0;
                     state         <= GAPW;
                  end
               end
            end
            GAPW: begin
               if (gap_cnt == GW'(GAP - 1)) begin
                  gap_cnt       <= '0;
                  bus.select    <= next_lane;
                  bus.out_data  <= snap_data[next_lane*WIDTH +: WIDTH];
                  bus.out_valid <= 1'b1;
                  state         <= SCAN;
               end else begin
                  gap_cnt <= gap_cnt + GW'(1);
               end
            end
            DONE: begin
               bus.done <= 1'b0;
               if (CONTINUOUS != 0) begin
                  state <= CAPTURE;
               end else begin
                  state    <= IDLE;
                  bus.busy <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_tdm_scan_ctrl.sv
// Directed bench for tdm_scan_ctrl: a GAP=0 instance for framing/handshake/reset cases
// and a GAP=2 instance for gap timing. Inputs change #1 after posedge; outputs read then.
module tb_tdm_scan_ctrl;
   logic clk;
   logic rst;
   logic [2:0] dbg_a;
   logic [2:0] dbg_g;
   int checks;
   int errors;

   tdm_scan_if #(.WIDTH(1)) bus_a ();
   tdm_scan_if #(.WIDTH(1)) bus_g ();

   tdm_scan_ctrl #(.WIDTH(1), .GAP(0), .CONTINUOUS(0)) u_dut (
      .clk(clk), .rst(rst), .bus(bus_a.slave), .dbg_state(dbg_a)
   );

   tdm_scan_ctrl #(.WIDTH(1), .GAP(2), .CONTINUOUS(0)) u_gap (
      .clk(clk), .rst(rst), .bus(bus_g.slave), .dbg_state(dbg_g)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_beat(input string tag, input logic v, input logic [1:0] s,
                             input logic d, input logic fs, input logic [1:0] es,
                             input logic ed, input logic efs);
      check({tag, ".valid"}, 32'(v), 32'd1);
      check({tag, ".select"}, 32'(s), 32'(es));
      check({tag, ".data"}, 32'(d), 32'(ed));
      check({tag, ".frame_start"}, 32'(fs), 32'(efs));
   endtask

   task automatic check_idle_a(input string tag, input logic [1:0] es);
      check({tag, ".valid"}, 32'(bus_a.out_valid), 32'd0);
      check({tag, ".busy"}, 32'(bus_a.busy), 32'd0);
      check({tag, ".done"}, 32'(bus_a.done), 32'd0);
      check({tag, ".select"}, 32'(bus_a.select), 32'(es));
      check({tag, ".state"}, 32'(dbg_a), 32'd0);
   endtask

   task automatic check_done_a(input string tag);
      check({tag, ".done"}, 32'(bus_a.done), 32'd1);
      check({tag, ".valid"}, 32'(bus_a.out_valid), 32'd0);
      check({tag, ".busy"}, 32'(bus_a.busy), 32'd1);
   endtask

   // driver: start pulse sampled at the next edge; leaves the DUT in its CAPTURE cycle
   task automatic start_a(input logic [3:0] mask, input logic [3:0] data);
      bus_a.lane_mask = mask;
      bus_a.in_data   = data;
      bus_a.start     = 1'b1;
      tick();
      bus_a.start = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus_a.start = 1'b0; bus_a.lane_mask = 4'd0; bus_a.in_data = 4'd0; bus_a.out_ready = 1'b1;
      bus_g.start = 1'b0; bus_g.lane_mask = 4'd0; bus_g.in_data = 4'd0; bus_g.out_ready = 1'b1;

      // 1: reset values
      tick();
      tick();
      rst = 1'b0;
      tick();
      check_idle_a("t1", 2'd0);
      check("t1.out_data", 32'(bus_a.out_data), 32'd0);
      check("t1.frame_start", 32'(bus_a.frame_start), 32'd0);
      check("t1.gap_valid", 32'(bus_g.out_valid), 32'd0);
      check("t1.gap_busy", 32'(bus_g.busy), 32'd0);

      // 2: all lanes, lane 3 set, ready held high
      start_a(4'b1111, 4'b1000);
      check("t2.cap_state", 32'(dbg_a), 32'd1);
      check("t2.cap_busy", 32'(bus_a.busy), 32'd1);
      check("t2.cap_valid", 32'(bus_a.out_valid), 32'd0);
      tick(); check_beat("t2.b0", bus_a.out_valid, bus_a.select, bus_a.out_data, bus_a.frame_start, 2'd0, 1'b0, 1'b1);
      tick(); check_beat("t2.b1", bus_a.out_valid, bus_a.select, bus_a.out_data, bus_a.frame_start, 2'd1, 1'b0, 1'b0);
      tick(); check_beat("t2.b2", bus_a.out_valid, bus_a.select, bus_a.out_data, bus_a.frame_start, 2'd2, 1'b0, 1'b0);
      tick(); check_beat("t2.b3", bus_a.out_valid, bus_a.select, bus_a.out_data, bus_a.frame_start, 2'd3, 1'b1, 1'b0);
      tick(); check_done_a("t2.done");
      tick(); check_idle_a("t2.idle", 2'd3);

      // 3: sparse mask 0101
      start_a(4'b0101, 4'b0100);
      tick(); check_beat("t3.b0", bus_a.out_valid, bus_a.select, bus_a.out_data, bus_a.frame_start, 2'd0, 1'b0, 1'b1);
      tick(); check_beat("t3.b1", bus_a.out_valid, bus_a.select, bus_a.out_data, bus_a.frame_start, 2'd2, 1'b1, 1'b0);
      tick(); check_done_a("t3.done");
      tick(); check_idle_a("t3.idle", 2'd2);

      // 4: backpressure on the lane-1 beat
      start_a(4'b1111, 4'b0010);
      tick(); check_beat("t4.b0", bus_a.out_valid, bus_a.select, bus_a.out_data, bus_a.frame_start, 2'd0, 1'b0, 1'b1);
      tick(); check_beat("t4.b1", bus_a.out_valid, bus_a.select, bus_a.out_data, bus_a.frame_start, 2'd1, 1'b1, 1'b0);
      bus_a.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_beat($sformatf("t4.hold%0d", i), bus_a.out_valid, bus_a.select, bus_a.out_data,
                    bus_a.frame_start, 2'd1, 1'b1, 1'b0);
      end
      bus_a.out_ready = 1'b1;
      tick(); check_beat("t4.b2", bus_a.out_valid, bus_a.select, bus_a.out_data, bus_a.frame_start, 2'd2, 1'b0, 1'b0);
      tick(); check_beat("t4.b3", bus_a.out_valid, bus_a.select, bus_a.out_data, bus_a.frame_start, 2'd3, 1'b0, 1'b0);
      tick(); check_done_a("t4.done");
      tick(); check_idle_a("t4.idle", 2'd3);

      // 5: inputs churn after CAPTURE, start pulsed while busy; snapshot is 0110
      start_a(4'b1111, 4'b0110);
      tick();
      bus_a.in_data = 4'b1001; bus_a.lane_mask = 4'b0001; bus_a.start = 1'b1;
      check_beat("t5.b0", bus_a.out_valid, bus_a.select, bus_a.out_data, bus_a.frame_start, 2'd0, 1'b0, 1'b1);
      tick();
      bus_a.in_data = 4'b0110; bus_a.start = 1'b0;
      check_beat("t5.b1", bus_a.out_valid, bus_a.select, bus_a.out_data, bus_a.frame_start, 2'd1, 1'b1, 1'b0);
      tick();
      bus_a.in_data = 4'b1001; bus_a.start = 1'b1;
      check_beat("t5.b2", bus_a.out_valid, bus_a.select, bus_a.out_data, bus_a.frame_start, 2'd2, 1'b1, 1'b0);
      tick();
      bus_a.in_data = 4'b0000; bus_a.start = 1'b0;
      check_beat("t5.b3", bus_a.out_valid, bus_a.select, bus_a.out_data, bus_a.frame_start, 2'd3, 1'b0, 1'b0);
      tick(); check_done_a("t5.done");
      tick(); check_idle_a("t5.idle", 2'd3);
      tick(); check_idle_a("t5.idle2", 2'd3);

      // 6a: reset in the middle of the lane-2 beat
      start_a(4'b1111, 4'b1111);
      tick(); tick(); tick();
      check_beat("t6.b2", bus_a.out_valid, bus_a.select, bus_a.out_data, bus_a.frame_start, 2'd2, 1'b1, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_idle_a("t6.rst", 2'd0);
      check("t6.rst_data", 32'(bus_a.out_data), 32'd0);
      tick();
      check_idle_a("t6.after", 2'd0);

      // 6b: start with an empty mask is ignored
      start_a(4'b0000, 4'b1111);
      check_idle_a("t6.mask0", 2'd0);
      tick();
      check_idle_a("t6.mask0b", 2'd0);

      // 6c: GAP=2 instance, lanes 0,1,3 with data 0,1,1
      bus_g.lane_mask = 4'b1011; bus_g.in_data = 4'b1010; bus_g.start = 1'b1;
      tick();
      bus_g.start = 1'b0;
      check("t6g.cap_busy", 32'(bus_g.busy), 32'd1);
      tick(); check_beat("t6g.b0", bus_g.out_valid, bus_g.select, bus_g.out_data, bus_g.frame_start, 2'd0, 1'b0, 1'b1);
      for (int i = 0; i < 2; i++) begin
         tick();
         check($sformatf("t6g.gap0_%0d", i), 32'(bus_g.out_valid), 32'd0);
      end
      tick(); check_beat("t6g.b1", bus_g.out_valid, bus_g.select, bus_g.out_data, bus_g.frame_start, 2'd1, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) begin
         tick();
         check($sformatf("t6g.gap1_%0d", i), 32'(bus_g.out_valid), 32'd0);
         check($sformatf("t6g.gap1_state%0d", i), 32'(dbg_g), 32'd3);
      end
      tick(); check_beat("t6g.b2", bus_g.out_valid, bus_g.select, bus_g.out_data, bus_g.frame_start, 2'd3, 1'b1, 1'b0);
      tick();
      check("t6g.done", 32'(bus_g.done), 32'd1);
      check("t6g.done_valid", 32'(bus_g.out_valid), 32'd0);
      tick();
      check("t6g.idle_busy", 32'(bus_g.busy), 32'd0);
      check("t6g.idle_done", 32'(bus_g.done), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
